// File: rtl/dram_cache_line_ctrl.sv
// Cache miss handler for dram_main_mem: optional dirty-victim writeback, then a word-by-word line refill.
// Writeback hardware is built only when DRAM_CACHE_WRITEBACK_EN is defined; otherwise write-through.
module dram_cache_line_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [DATA_WIDTH-1:0]            req_addr,
   input  logic                             victim_dirty,
   input  logic [DATA_WIDTH-1:0]            victim_addr,
   input  logic [DATA_WIDTH*LINE_WORDS-1:0] victim_line,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic [DATA_WIDTH*LINE_WORDS-1:0] resp_line,
   output logic [DATA_WIDTH-1:0]            mem_w_addr,
   output logic [DATA_WIDTH-1:0]            mem_wd,
   output logic                             mem_we,
   output logic [DATA_WIDTH-1:0]            mem_r_addr,
   output logic                             mem_re,
   input  logic [DATA_WIDTH-1:0]            mem_rd
);
   localparam int CNT_W = $clog2(LINE_WORDS);
   localparam int OFF_W = $clog2(LINE_WORDS * 4);

   typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

   state_t                state, state_nx;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] req_base;
   logic [DATA_WIDTH-1:0] fill_buf [LINE_WORDS];
   logic [DATA_WIDTH-1:0] word_off;
   logic                  last;
   logic                  accept;
   logic                  unused_inputs;

   assign last     = (cnt == CNT_W'(LINE_WORDS - 1));
   assign word_off = DATA_WIDTH'(cnt) << 2;
   assign accept   = req_valid && (state == IDLE);

   always_comb begin
      // NOTE: state_nx is given a default before the case so no path leaves it unassigned (no latch).
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
`ifdef DRAM_CACHE_WRITEBACK_EN
               state_nx = victim_dirty ? WB : FILL;
`else
               state_nx = FILL;
`endif
            end
         end
         WB:      if (last) state_nx = FILL;
         FILL:    if (last) state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         req_base <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_nx;
         if ((state_nx != state) || (state == IDLE) || (state == RESP)) cnt <= '0;
         else                                                          cnt <= cnt + CNT_W'(1);
         if (accept) req_base <= {req_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the fill buffer is reset because resp_line is visible straight out of reset.
         for (int i = 0; i < LINE_WORDS; i++) fill_buf[i] <= '0;
      end else if (state == FILL) begin
         fill_buf[cnt] <= mem_rd;
      end
   end

`ifdef DRAM_CACHE_WRITEBACK_EN
   logic [DATA_WIDTH-1:0] vic_base;
   logic [DATA_WIDTH-1:0] vic_line [LINE_WORDS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vic_base <= '0;
         for (int i = 0; i < LINE_WORDS; i++) vic_line[i] <= '0;
      end else if (accept) begin
         vic_base <= {victim_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
         for (int i = 0; i < LINE_WORDS; i++) vic_line[i] <= victim_line[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign unused_inputs = ^{victim_addr[OFF_W-1:0], req_addr[OFF_W-1:0]};
`else
   assign unused_inputs = ^{victim_dirty, victim_addr, victim_line, req_addr[OFF_W-1:0]};
`endif

   // Strobes are pure state decodes; address/data lines are zero whenever their strobe is low.
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      mem_re     = (state == FILL);
      mem_r_addr = mem_re ? (req_base + word_off) : '0;
      for (int i = 0; i < LINE_WORDS; i++) resp_line[i*DATA_WIDTH +: DATA_WIDTH] = fill_buf[i];
`ifdef DRAM_CACHE_WRITEBACK_EN
      mem_we     = (state == WB);
      mem_w_addr = mem_we ? (vic_base + word_off) : '0;
      mem_wd     = mem_we ? vic_line[cnt] : '0;
`else
      mem_we     = 1'b0;
      mem_w_addr = '0;
      mem_wd     = '0;
`endif
   end

endmodule
